serial_sub_ctrl: RTL and testbench

Bit-serial N-bit subtractor controller. It computes a - b - bin by sequencing a single one-bit full-subtractor cell over WIDTH clock cycles, LSB first. It has a start/done handshake and holds its result. It sits beside the team's combinational full-subtractor cell and reuses that cell as its only arithmetic resource.

---
 rtl/serial_sub_ctrl_pkg.sv | 16 +
 rtl/full_sub_bit.sv | 19 +
 rtl/serial_sub_ctrl.sv | 121 ++++++++++++
 tb/tb_serial_sub_ctrl.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_sub_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serial_sub_ctrl_pkg
// Description : Shared constants for the bit-serial subtractor controller.
// Revision    : 1.0 - initial release
// ============================================================================
package serial_sub_ctrl_pkg;

    localparam int DEFAULT_WIDTH = 8;

    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_RUN  = 2'b01;
    localparam logic [1:0] S_DONE = 2'b10;

endpackage : serial_sub_ctrl_pkg
`default_nettype wire

// File: rtl/full_sub_bit.sv
`default_nettype none
// ============================================================================
// Module      : full_sub_bit
// Description : Combinational one-bit full subtractor (a - b - bin).
// Revision    : 1.0 - initial release
// ============================================================================
module full_sub_bit (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bo
);

    assign d  = a ^ b ^ bin;
    assign bo = (~a & b) | (~(a ^ b) & bin);

endmodule : full_sub_bit
`default_nettype wire

// File: rtl/serial_sub_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : serial_sub_ctrl
// Description : Bit-serial WIDTH-bit subtractor, LSB first, start/done handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_sub_ctrl
    import serial_sub_ctrl_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    localparam int                c_CNT_W = $clog2(WIDTH);
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(WIDTH - 1);

    logic [1:0]         r_state;
    logic [1:0]         w_state_next;
    logic [WIDTH-1:0]   r_sa;
    logic [WIDTH-1:0]   r_sb;
    logic               r_br;
    logic [c_CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0]   r_diff;
    logic               r_bout;
    logic               r_ovf;
    logic               r_a_sign;
    logic               r_b_sign;
    logic               w_d;
    logic               w_bo;
    logic               w_last;

    full_sub_bit u_cell (
        .a   (r_sa[0]),
        .b   (r_sb[0]),
        .bin (r_br),
        .d   (w_d),
        .bo  (w_bo)
    );

    assign w_last = (r_cnt == c_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_next = S_RUN;
            S_RUN:   if (w_last) w_state_next = S_DONE;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sa     <= '0;
            r_sb     <= '0;
            r_br     <= 1'b0;
            r_cnt    <= '0;
            r_diff   <= '0;
            r_bout   <= 1'b0;
            r_ovf    <= 1'b0;
            r_a_sign <= 1'b0;
            r_b_sign <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_sa     <= a;
                        r_sb     <= b;
                        r_br     <= bin;
                        r_cnt    <= '0;
                        r_a_sign <= a[WIDTH-1];
                        r_b_sign <= b[WIDTH-1];
                    end
                end
                S_RUN: begin
                    r_sa   <= {1'b0, r_sa[WIDTH-1:1]};
                    r_sb   <= {1'b0, r_sb[WIDTH-1:1]};
                    r_diff <= {w_d, r_diff[WIDTH-1:1]};
                    r_br   <= w_bo;
                    // Counter parks on the terminal value so it never wraps.
                    if (!w_last) begin
                        r_cnt <= r_cnt + c_CNT_W'(1);
                    end else begin
                        r_bout <= w_bo;
                        r_ovf  <= (r_a_sign != r_b_sign) && (w_d != r_a_sign);
                    end
                end
                default: ;
            endcase
        end
    end

    assign ready = (r_state == S_IDLE);
    assign busy  = (r_state == S_RUN);
    assign done  = (r_state == S_DONE);
    assign diff  = r_diff;
    assign bout  = r_bout;
    assign ovf   = r_ovf;

endmodule : serial_sub_ctrl
`default_nettype wire

// File: tb/tb_serial_sub_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_sub_ctrl
// Description : Self-checking bench for serial_sub_ctrl (WIDTH=8 and WIDTH=3).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_sub_ctrl;

    localparam int W8 = 8;
    localparam int W3 = 3;

    typedef struct packed {
        logic [7:0] diff;
        logic       bout;
        logic       ovf;
    } exp8_t;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       bin;
        logic [7:0] diff;
        logic       bout;
        logic       ovf;
    } vec_t;

    logic          clk;
    logic          rst_n;
    logic          start8, bin8, ready8, busy8, done8, bout8, ovf8;
    logic [W8-1:0] a8, b8, diff8;
    logic          start3, bin3, ready3, busy3, done3, bout3, ovf3;
    logic [W3-1:0] a3, b3, diff3;

    int    n_vec;
    int    n_err;
    exp8_t q8[$];
    exp8_t q3[$];
    vec_t  vecs[8];

    serial_sub_ctrl #(.WIDTH(W8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .bin(bin8),
        .ready(ready8), .busy(busy8), .done(done8), .diff(diff8), .bout(bout8), .ovf(ovf8)
    );

    serial_sub_ctrl #(.WIDTH(W3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .a(a3), .b(b3), .bin(bin3),
        .ready(ready3), .busy(busy3), .done(done3), .diff(diff3), .bout(bout3), .ovf(ovf3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboards: an expected result is popped on each done pulse.
    always @(negedge clk) begin
        if (done8) begin
            if (q8.size() == 0) begin
                chk("sb8_unexpected_done", 1, 0);
            end else begin
                exp8_t e;
                e = q8.pop_front();
                chk("sb8_diff", diff8, e.diff);
                chk("sb8_bout", bout8, e.bout);
                chk("sb8_ovf",  ovf8,  e.ovf);
            end
        end
        if (done3) begin
            if (q3.size() == 0) begin
                chk("sb3_unexpected_done", 1, 0);
            end else begin
                exp8_t e;
                e = q3.pop_front();
                chk("sb3_diff", diff3, e.diff[2:0]);
                chk("sb3_bout", bout3, e.bout);
                chk("sb3_ovf",  ovf3,  e.ovf);
            end
        end
    end

    task automatic wait_ready8();
        int k = 0;
        while (!ready8 && k < 50) begin
            @(posedge clk); #1; k++;
        end
        chk("ready8_wait", ready8, 1);
    endtask

    task automatic run8(input logic [7:0] ia, input logic [7:0] ib, input logic ibin,
                        input exp8_t e, input bit glitch);
        int n;
        wait_ready8();
        a8 = ia; b8 = ib; bin8 = ibin; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        q8.push_back(e);
        chk("accept_ready", ready8, 0);
        chk("accept_busy",  busy8,  1);
        n = 0;
        while (!done8 && n < 4 * W8) begin
            @(posedge clk); #1; n++;
            if (glitch && n == 2) begin
                start8 = 1'b1; a8 = ~ia; b8 = ~ib; bin8 = ~ibin;
            end else begin
                start8 = 1'b0;
            end
            if (!done8) chk("run_ready_low", ready8, 0);
        end
        chk("done_latency", n, W8);
        chk("done_busy_low", busy8, 0);
        if (glitch) begin
            start8 = 1'b1; a8 = 8'h00; b8 = 8'hFF;
        end
        @(posedge clk); #1;
        start8 = 1'b0;
        chk("done_one_cycle", done8, 0);
        chk("ready_return",   ready8, 1);
        chk("hold_diff", diff8, e.diff);
        chk("hold_bout", bout8, e.bout);
        chk("hold_ovf",  ovf8,  e.ovf);
        if (glitch) begin
            @(posedge clk); #1;
            chk("done_start_ignored", busy8, 0);
            chk("idle_hold_diff", diff8, e.diff);
        end
    endtask

    task automatic run3(input logic [2:0] ia, input logic [2:0] ib, input logic ibin);
        logic [3:0] full;
        int sa, sb, sr, n;
        exp8_t e;
        full = {1'b0, ia} - {1'b0, ib} - {3'b000, ibin};
        sa = ia[2] ? int'(ia) - 8 : int'(ia);
        sb = ib[2] ? int'(ib) - 8 : int'(ib);
        sr = sa - sb - int'(ibin);
        e.diff = {5'b00000, full[2:0]};
        e.bout = full[3];
        e.ovf  = (sr < -4) || (sr > 3);
        n = 0;
        while (!ready3 && n < 20) begin
            @(posedge clk); #1; n++;
        end
        a3 = ia; b3 = ib; bin3 = ibin; start3 = 1'b1;
        @(posedge clk); #1;
        start3 = 1'b0;
        q3.push_back(e);
        n = 0;
        while (!done3 && n < 20) begin
            @(posedge clk); #1; n++;
        end
        if (!done3) chk("dut3_done_timeout", done3, 1);
        @(posedge clk); #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int t[3];
        int k, n;

        vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0, 1'b0};
        vecs[1] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0};
        vecs[2] = '{8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, 1'b0};
        vecs[3] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
        vecs[4] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1};
        vecs[5] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
        vecs[6] = '{8'h00, 8'h80, 1'b0, 8'h80, 1'b1, 1'b1};
        vecs[7] = '{8'h33, 8'h44, 1'b1, 8'hEE, 1'b1, 1'b0};

        n_vec = 0; n_err = 0;
        rst_n = 1'b0;
        start8 = 0; a8 = '0; b8 = '0; bin8 = 0;
        start3 = 0; a3 = '0; b3 = '0; bin3 = 0;
        #8;
        chk("rst_ready", ready8, 1);
        chk("rst_busy",  busy8,  0);
        chk("rst_done",  done8,  0);
        chk("rst_diff",  diff8,  0);
        chk("rst_bout",  bout8,  0);
        chk("rst_ovf",   ovf8,   0);
        #4 rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++) begin
            run8(vecs[i].a, vecs[i].b, vecs[i].bin,
                 '{diff: vecs[i].diff, bout: vecs[i].bout, ovf: vecs[i].ovf}, 1'b0);
        end

        // Re-pulsed start in RUN and in DONE must not disturb the first result.
        run8(8'h5A, 8'h3C, 1'b0, '{diff: 8'h1E, bout: 1'b0, ovf: 1'b0}, 1'b1);

        // Start held high: back-to-back operations WIDTH+2 cycles apart.
        wait_ready8();
        a8 = 8'h80; b8 = 8'h01; bin8 = 1'b0;
        for (int i = 0; i < 3; i++) q8.push_back('{diff: 8'h7F, bout: 1'b0, ovf: 1'b1});
        start8 = 1'b1;
        k = 0; n = 0;
        while (k < 3 && n < 60) begin
            @(posedge clk); #1; n++;
            if (done8) begin
                t[k] = n; k++;
            end
        end
        start8 = 1'b0;
        chk("held_start_count", k, 3);
        chk("held_start_gap1", t[1] - t[0], W8 + 2);
        chk("held_start_gap2", t[2] - t[1], W8 + 2);
        @(posedge clk); #1;
        chk("held_start_idle", ready8, 1);

        // Asynchronous reset during RUN cycle 4.
        wait_ready8();
        a8 = 8'h5A; b8 = 8'h3C; bin8 = 1'b0; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("midrst_ready", ready8, 1);
        chk("midrst_busy",  busy8,  0);
        chk("midrst_done",  done8,  0);
        chk("midrst_diff",  diff8,  0);
        chk("midrst_bout",  bout8,  0);
        chk("midrst_ovf",   ovf8,   0);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("midrst_still_idle", ready8, 1);
        run8(8'hC8, 8'h64, 1'b0, '{diff: 8'h64, bout: 1'b0, ovf: 1'b1}, 1'b0);

        for (int ia = 0; ia < 8; ia++)
            for (int ib = 0; ib < 8; ib++)
                for (int ic = 0; ic < 2; ic++)
                    run3(3'(ia), 3'(ib), 1'(ic));

        repeat (4) @(posedge clk);
        #1;
        chk("sb8_drained", q8.size(), 0);
        chk("sb3_drained", q3.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_serial_sub_ctrl
`default_nettype wire
